// File: rtl/mips_pkg.sv
// Shared MIPS encodings and control-state codes for the fetch stage and the multicycle control FSM.
package mips_pkg;

    typedef enum logic [5:0] {
        OpFunct = 6'h00,
        OpBeq   = 6'h04,
        OpBne   = 6'h05,
        OpLui   = 6'h0f,
        OpLw    = 6'h23,
        OpSw    = 6'h2b
    } OpCodeEnum;

    typedef enum logic [5:0] {
        FnNop   = 6'h00,
        FnBreak = 6'h0d,
        FnAdd   = 6'h20,
        FnSub   = 6'h22,
        FnAnd   = 6'h24,
        FnXor   = 6'h26
    } FunctEnum;

    localparam logic [7:0] S_FETCH   = 8'd0;
    localparam logic [7:0] S_DELAY1  = 8'd1;
    localparam logic [7:0] S_DELAY2  = 8'd2;
    localparam logic [7:0] S_DECODE  = 8'd3;
    localparam logic [7:0] S_BEQ     = 8'd4;
    localparam logic [7:0] S_BNE     = 8'd5;
    localparam logic [7:0] S_LW      = 8'd6;
    localparam logic [7:0] S_SW      = 8'd7;
    localparam logic [7:0] S_LUI     = 8'd8;
    localparam logic [7:0] S_ADD     = 8'd9;
    localparam logic [7:0] S_AND     = 8'd10;
    localparam logic [7:0] S_SUB     = 8'd11;
    localparam logic [7:0] S_XOR     = 8'd12;
    localparam logic [7:0] S_BREAK   = 8'd13;
    localparam logic [7:0] S_NOP     = 8'd14;
    localparam logic [7:0] S_ILLEGAL = 8'd15;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StHalt
    } fetch_state_e;

    function automatic logic op_known(input logic [5:0] op);
        case (op)
            OpFunct, OpBeq, OpBne, OpLui, OpLw, OpSw: return 1'b1;
            default:                                  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/fetch_funct_decode.sv
// Combinational R-type funct -> control state code. FETCH_ILLEGAL_TRAP_EN maps unknown
// functs to S_ILLEGAL instead of S_NOP.
module fetch_funct_decode
    import mips_pkg::*;
(
    input  logic [5:0] funct_i,
    output logic [7:0] state_o,
    output logic       illegal_o
);

    always_comb begin
        state_o   = S_NOP;
        illegal_o = 1'b0;
        case (funct_i)
            FnAdd:   state_o = S_ADD;
            FnAnd:   state_o = S_AND;
            FnSub:   state_o = S_SUB;
            FnXor:   state_o = S_XOR;
            FnBreak: state_o = S_BREAK;
            FnNop:   state_o = S_NOP;
            default: begin
                illegal_o = 1'b1;
`ifdef FETCH_ILLEGAL_TRAP_EN
                state_o   = S_ILLEGAL;
`endif
            end
        endcase
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: reads memory at PC, waits out MEM_LATENCY, captures and decodes the word.
// FETCH_ILLEGAL_TRAP_EN adds a sticky illegal output and halts on unknown encodings.
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 3,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             fetch_req,
    input  logic [31:0]      pc,
    output logic [31:0]      mem_addr,
    output logic             mem_rd,
    input  logic [31:0]      mem_rdata,
    output logic [31:0]      Instr,
    output logic [5:0]       Op,
    output logic [5:0]       Funct,
    output logic [4:0]       Rs,
    output logic [4:0]       Rt,
    output logic [4:0]       Rd,
    output logic [4:0]       Shamt,
    output logic [15:0]      Imm,
    output logic [7:0]       nextFunctState,
    output logic             instr_valid,
    output logic             busy,
    output logic             halted,
`ifdef FETCH_ILLEGAL_TRAP_EN
    output logic             illegal,
`endif
    output logic [CNT_W-1:0] fetch_count
);

    localparam logic [3:0] CntInit = 4'(MEM_LATENCY - 1);

    fetch_state_e     state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      instr_q, instr_d;
    logic [7:0]       nfs_q, nfs_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [7:0] dec_state;
    logic       dec_illegal;
    logic       is_break;
    logic       trap;
    logic       capture;

    fetch_funct_decode u_decode (
        .funct_i   (mem_rdata[5:0]),
        .state_o   (dec_state),
        .illegal_o (dec_illegal)
    );

    assign is_break = (mem_rdata[31:26] == OpFunct) && (mem_rdata[5:0] == FnBreak);
    assign capture  = (state_q == StWait) && (cnt_q == 4'd0);

`ifdef FETCH_ILLEGAL_TRAP_EN
    assign trap = !op_known(mem_rdata[31:26]) ||
                  ((mem_rdata[31:26] == OpFunct) && dec_illegal);
`else
    logic unused_dec_illegal;
    assign unused_dec_illegal = dec_illegal;
    assign trap = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        instr_d = instr_q;
        nfs_d   = nfs_q;
        valid_d = valid_q;
        count_d = count_q;
        case (state_q)
            StIdle: begin
                if (fetch_req) begin
                    addr_d  = pc;
                    cnt_d   = CntInit;
                    valid_d = 1'b0;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    instr_d = mem_rdata;
                    nfs_d   = dec_state;
                    valid_d = 1'b1;
                    count_d = count_q + CNT_W'(1);
                    state_d = (is_break || trap) ? StHalt : StIdle;
                end
            end
            StHalt:  ;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            instr_q <= 32'd0;
            nfs_q   <= S_NOP;
            valid_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            nfs_q   <= nfs_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

`ifdef FETCH_ILLEGAL_TRAP_EN
    logic illegal_q;
    always_ff @(posedge Clk) begin
        if (Reset) begin
            illegal_q <= 1'b0;
        end else if (capture && trap) begin
            illegal_q <= 1'b1;
        end
    end
    assign illegal = illegal_q;
`endif

    assign mem_addr       = addr_q;
    assign mem_rd         = (state_q == StWait);
    assign busy           = (state_q == StWait);
    assign halted         = (state_q == StHalt);
    assign Instr          = instr_q;
    assign nextFunctState = nfs_q;
    assign instr_valid    = valid_q;
    assign fetch_count    = count_q;

    assign Op    = instr_q[31:26];
    assign Rs    = instr_q[25:21];
    assign Rt    = instr_q[20:16];
    assign Rd    = instr_q[15:11];
    assign Shamt = instr_q[10:6];
    assign Funct = instr_q[5:0];
    assign Imm   = instr_q[15:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: latency-3/16-bit-count instance plus a latency-1/4-bit one.
module tb_instr_fetch_unit;
    import mips_pkg::*;

    logic        Clk;
    logic        Reset;
    logic        fetch_req, fetch_req1;
    logic [31:0] pc, pc1;
    logic [31:0] mem_rdata, mem_rdata1;

    logic [31:0] mem_addr, mem_addr1;
    logic        mem_rd, mem_rd1;
    logic [31:0] Instr, Instr1;
    logic [5:0]  Op, Op1, Funct, Funct1;
    logic [4:0]  Rs, Rs1, Rt, Rt1, Rd, Rd1, Shamt, Shamt1;
    logic [15:0] Imm, Imm1;
    logic [7:0]  nfs, nfs1;
    logic        instr_valid, instr_valid1;
    logic        busy, busy1;
    logic        halted, halted1;
    logic [15:0] fetch_count;
    logic [3:0]  fetch_count1;
`ifdef FETCH_ILLEGAL_TRAP_EN
    logic        illegal, illegal1;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    instr_fetch_unit #(.MEM_LATENCY(3), .CNT_W(16)) u_dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .fetch_req      (fetch_req),
        .pc             (pc),
        .mem_addr       (mem_addr),
        .mem_rd         (mem_rd),
        .mem_rdata      (mem_rdata),
        .Instr          (Instr),
        .Op             (Op),
        .Funct          (Funct),
        .Rs             (Rs),
        .Rt             (Rt),
        .Rd             (Rd),
        .Shamt          (Shamt),
        .Imm            (Imm),
        .nextFunctState (nfs),
        .instr_valid    (instr_valid),
        .busy           (busy),
        .halted         (halted),
`ifdef FETCH_ILLEGAL_TRAP_EN
        .illegal        (illegal),
`endif
        .fetch_count    (fetch_count)
    );

    instr_fetch_unit #(.MEM_LATENCY(1), .CNT_W(4)) u_dut1 (
        .Clk            (Clk),
        .Reset          (Reset),
        .fetch_req      (fetch_req1),
        .pc             (pc1),
        .mem_addr       (mem_addr1),
        .mem_rd         (mem_rd1),
        .mem_rdata      (mem_rdata1),
        .Instr          (Instr1),
        .Op             (Op1),
        .Funct          (Funct1),
        .Rs             (Rs1),
        .Rt             (Rt1),
        .Rd             (Rd1),
        .Shamt          (Shamt1),
        .Imm            (Imm1),
        .nextFunctState (nfs1),
        .instr_valid    (instr_valid1),
        .busy           (busy1),
        .halted         (halted1),
`ifdef FETCH_ILLEGAL_TRAP_EN
        .illegal        (illegal1),
`endif
        .fetch_count    (fetch_count1)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic reset_dut();
        @(negedge Clk);
        Reset      = 1'b1;
        fetch_req  = 1'b0;
        fetch_req1 = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    // Issues one request and returns at the first negedge with mem_rd low, reporting its length.
    task automatic do_fetch(input logic [31:0] a, input logic [31:0] d, input bit hold,
                            output int rd_cycles);
        @(negedge Clk);
        pc        = a;
        mem_rdata = d;
        fetch_req = 1'b1;
        @(negedge Clk);
        if (!hold) fetch_req = 1'b0;
        rd_cycles = 0;
        for (int i = 0; i < 20 && mem_rd; i++) begin
            rd_cycles++;
            @(negedge Clk);
        end
        fetch_req = 1'b0;
    endtask

    task automatic test_reset();
        reset_dut();
        n_cmp++; if (Instr !== 32'd0) begin n_fail++; $display("FAIL reset_instr got %h exp 0", Instr); end
        n_cmp++; if (mem_addr !== 32'd0) begin n_fail++; $display("FAIL reset_addr got %h exp 0", mem_addr); end
        n_cmp++; if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL reset_mem_rd got %b exp 0", mem_rd); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", instr_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_cmp++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got %b exp 0", halted); end
        n_cmp++; if (fetch_count !== 16'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", fetch_count); end
        n_cmp++; if (nfs !== 8'd14) begin n_fail++; $display("FAIL reset_nfs got %0d exp 14", nfs); end
    endtask

    task automatic test_add();
        int cyc;
        do_fetch(32'h40, 32'h012A4020, 1'b0, cyc);
        n_cmp++; if (cyc !== 3) begin n_fail++; $display("FAIL add_rd_cycles got %0d exp 3", cyc); end
        n_cmp++; if (mem_addr !== 32'h40) begin n_fail++; $display("FAIL add_addr got %h exp 40", mem_addr); end
        n_cmp++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid got %b exp 1", instr_valid); end
        n_cmp++; if (Instr !== 32'h012A4020) begin n_fail++; $display("FAIL add_instr got %h exp 012a4020", Instr); end
        n_cmp++; if (Rs !== 5'd9) begin n_fail++; $display("FAIL add_rs got %0d exp 9", Rs); end
        n_cmp++; if (Rt !== 5'd10) begin n_fail++; $display("FAIL add_rt got %0d exp 10", Rt); end
        n_cmp++; if (Rd !== 5'd8) begin n_fail++; $display("FAIL add_rd got %0d exp 8", Rd); end
        n_cmp++; if (Funct !== 6'h20) begin n_fail++; $display("FAIL add_funct got %h exp 20", Funct); end
        n_cmp++; if (nfs !== 8'd9) begin n_fail++; $display("FAIL add_nfs got %0d exp 9", nfs); end
        n_cmp++; if (fetch_count !== 16'd1) begin n_fail++; $display("FAIL add_count got %0d exp 1", fetch_count); end
        // valid must persist while idle
        @(negedge Clk);
        n_cmp++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid_hold got %b exp 1", instr_valid); end
    endtask

    task automatic test_lw_hold();
        int cyc;
        do_fetch(32'h44, 32'h8C220004, 1'b1, cyc);
        n_cmp++; if (cyc !== 3) begin n_fail++; $display("FAIL lw_rd_cycles got %0d exp 3", cyc); end
        n_cmp++; if (Op !== 6'h23) begin n_fail++; $display("FAIL lw_op got %h exp 23", Op); end
        n_cmp++; if (Imm !== 16'h0004) begin n_fail++; $display("FAIL lw_imm got %h exp 0004", Imm); end
        n_cmp++; if (Rs !== 5'd1 || Rt !== 5'd2) begin n_fail++; $display("FAIL lw_rs_rt got %0d/%0d exp 1/2", Rs, Rt); end
        n_cmp++; if (fetch_count !== 16'd2) begin n_fail++; $display("FAIL lw_count got %0d exp 2", fetch_count); end
        @(negedge Clk);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL lw_no_queue got busy %b exp 0", busy); end
    endtask

    task automatic test_break();
        int cyc;
        int rd_seen;
        do_fetch(32'h48, 32'h0000000D, 1'b0, cyc);
        n_cmp++; if (cyc !== 3) begin n_fail++; $display("FAIL brk_rd_cycles got %0d exp 3", cyc); end
        n_cmp++; if (halted !== 1'b1) begin n_fail++; $display("FAIL brk_halted got %b exp 1", halted); end
        n_cmp++; if (nfs !== 8'd13) begin n_fail++; $display("FAIL brk_nfs got %0d exp 13", nfs); end
        rd_seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            fetch_req = 1'b1;
            pc        = 32'h100;
            mem_rdata = 32'h012A4020;
            @(negedge Clk);
            fetch_req = 1'b0;
            if (mem_rd) rd_seen++;
            @(negedge Clk);
            if (mem_rd) rd_seen++;
        end
        n_cmp++; if (rd_seen !== 0) begin n_fail++; $display("FAIL brk_no_rd got %0d exp 0", rd_seen); end
        n_cmp++; if (Instr !== 32'h0000000D) begin n_fail++; $display("FAIL brk_instr_hold got %h exp 0000000d", Instr); end
        n_cmp++; if (halted !== 1'b1) begin n_fail++; $display("FAIL brk_sticky got %b exp 1", halted); end
        reset_dut();
        n_cmp++; if (halted !== 1'b0) begin n_fail++; $display("FAIL brk_reset_halted got %b exp 0", halted); end
        do_fetch(32'h4C, 32'h012A4020, 1'b0, cyc);
        n_cmp++; if (cyc !== 3) begin n_fail++; $display("FAIL brk_refetch_cycles got %0d exp 3", cyc); end
    endtask

    task automatic test_reset_mid_wait();
        @(negedge Clk);
        pc        = 32'h80;
        mem_rdata = 32'h8C220004;
        fetch_req = 1'b1;
        @(negedge Clk);
        fetch_req = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rmw_busy got %b exp 1", busy); end
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        n_cmp++; if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL rmw_mem_rd got %b exp 0", mem_rd); end
        n_cmp++; if (Instr !== 32'd0) begin n_fail++; $display("FAIL rmw_instr got %h exp 0", Instr); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rmw_valid got %b exp 0", instr_valid); end
        n_cmp++; if (fetch_count !== 16'd0) begin n_fail++; $display("FAIL rmw_count got %0d exp 0", fetch_count); end
        Reset = 1'b0;
        repeat (4) @(negedge Clk);
        n_cmp++; if (Instr !== 32'd0 || mem_rd !== 1'b0) begin
            n_fail++; $display("FAIL rmw_no_capture got instr %h rd %b exp 0/0", Instr, mem_rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        reset_dut();
        fetch_req1 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            d          = 32'h0000_0020 | (32'(i) << 11);
            mem_rdata1 = d;
            pc1        = 32'h200 + 32'(i * 4);
            @(negedge Clk);
            n_cmp++; if (mem_rd1 !== 1'b1) begin n_fail++; $display("FAIL b2b_rd[%0d] got %b exp 1", i, mem_rd1); end
            @(negedge Clk);
            n_cmp++; if (mem_rd1 !== 1'b0 || instr_valid1 !== 1'b1 || Instr1 !== d) begin
                n_fail++;
                $display("FAIL b2b_cap[%0d] got rd %b v %b instr %h exp 0/1/%h",
                         i, mem_rd1, instr_valid1, Instr1, d);
            end
            n_cmp++; if (fetch_count1 !== 4'(i + 1)) begin
                n_fail++; $display("FAIL b2b_count[%0d] got %0d exp %0d", i, fetch_count1, 4'(i + 1));
            end
        end
        fetch_req1 = 1'b0;
        n_cmp++; if (fetch_count1 !== 4'd0) begin n_fail++; $display("FAIL b2b_wrap got %0d exp 0", fetch_count1); end
    endtask

    task automatic test_unknown_funct();
        int cyc;
        reset_dut();
        do_fetch(32'h60, 32'h0000003F, 1'b0, cyc);
        n_cmp++; if (cyc !== 3) begin n_fail++; $display("FAIL unk_rd_cycles got %0d exp 3", cyc); end
`ifdef FETCH_ILLEGAL_TRAP_EN
        n_cmp++; if (illegal !== 1'b1) begin n_fail++; $display("FAIL unk_illegal got %b exp 1", illegal); end
        n_cmp++; if (halted !== 1'b1) begin n_fail++; $display("FAIL unk_halted got %b exp 1", halted); end
        n_cmp++; if (nfs !== 8'd15) begin n_fail++; $display("FAIL unk_nfs got %0d exp 15", nfs); end
        do_fetch(32'h64, 32'h012A4020, 1'b0, cyc);
        n_cmp++; if (cyc !== 0) begin n_fail++; $display("FAIL unk_no_fetch got %0d exp 0", cyc); end
`else
        n_cmp++; if (halted !== 1'b0) begin n_fail++; $display("FAIL unk_halted got %b exp 0", halted); end
        n_cmp++; if (nfs !== 8'd14) begin n_fail++; $display("FAIL unk_nfs got %0d exp 14", nfs); end
        do_fetch(32'h64, 32'h012A4020, 1'b0, cyc);
        n_cmp++; if (cyc !== 3) begin n_fail++; $display("FAIL unk_next_cycles got %0d exp 3", cyc); end
        n_cmp++; if (Instr !== 32'h012A4020 || fetch_count !== 16'd2) begin
            n_fail++; $display("FAIL unk_next got instr %h cnt %0d exp 012a4020/2", Instr, fetch_count);
        end
`endif
    endtask

    initial begin
        Reset      = 1'b1;
        fetch_req  = 1'b0;
        fetch_req1 = 1'b0;
        pc         = 32'd0;
        pc1        = 32'd0;
        mem_rdata  = 32'd0;
        mem_rdata1 = 32'd0;
        test_reset();
        test_add();
        test_lw_hold();
        test_break();
        test_reset_mid_wait();
        test_back_to_back();
        test_unknown_funct();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
